gate_truth_table_checker: RTL and testbench

Self-checking response end for the gate stimulus flow. It drives every input vector of an N-input combinational gate in ascending order, starting with {A,B}=00 and ending with 11. After each vector it waits a fixed settle time, samples the gate output, and compares it with a parameterised expected truth table. It counts mismatches and reports pass/fail together with the first failing vector. It sits on the FPGA next to the gate under test (the NAND cell by default) and replaces the simulation-only stimulus bench with a synthesizable driver and checker.

---
 rtl/gate_truth_table_checker.sv | 172 +++++++++++++++++
 tb/tb_gate_truth_table_checker.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_table_checker.sv
// Synthesizable stimulus/response checker for an N_IN-input combinational gate:
// drives every input vector in ascending order, samples the gate output and scores it.
module gate_truth_table_checker #(
  parameter int                     N_IN          = 2,
  parameter int                     SETTLE_CYCLES = 4,
  parameter logic [(2**N_IN)-1:0]   EXP_TABLE     = 4'b0111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [N_IN-1:0]   dut_in,
  input  logic              dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic              first_fail_valid,
  output logic [N_IN-1:0]   first_fail_vec
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;

  // Counter only ever holds SETTLE_CYCLES-1 down to 0.
  localparam int                CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
  localparam logic [N_IN-1:0]   VEC_ZERO = N_IN'(1'b0);
  localparam logic [N_IN-1:0]   VEC_ONE  = N_IN'(1'b1);
  localparam logic [N_IN-1:0]   VEC_LAST = {N_IN{1'b1}};
  localparam logic [N_IN:0]     ERR_ZERO = (N_IN+1)'(1'b0);
  localparam logic [N_IN:0]     ERR_ONE  = (N_IN+1)'(1'b1);

  function automatic logic expected_bit(input logic [N_IN-1:0] v);
    expected_bit = EXP_TABLE[v];
  endfunction

  logic [1:0]        state_r, state_s;
  logic [N_IN-1:0]   vec_r, vec_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [N_IN-1:0]   dut_in_r, dut_in_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              pass_r, pass_s;
  logic [N_IN:0]     err_r, err_s;
  logic              ffv_r, ffv_s;
  logic [N_IN-1:0]   ffvec_r, ffvec_s;
  logic              mismatch_s;

  // Next-state and next-output computation for the sweep sequencer.
  always_comb begin
    state_s    = state_r;
    vec_s      = vec_r;
    cnt_s      = cnt_r;
    dut_in_s   = dut_in_r;
    busy_s     = busy_r;
    done_s     = done_r;
    pass_s     = pass_r;
    err_s      = err_r;
    ffv_s      = ffv_r;
    ffvec_s    = ffvec_r;
    mismatch_s = (dut_out != expected_bit(vec_r));

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          err_s    = ERR_ZERO;
          ffv_s    = 1'b0;
          ffvec_s  = VEC_ZERO;
          done_s   = 1'b0;
          pass_s   = 1'b0;
          vec_s    = VEC_ZERO;
          cnt_s    = CNT_LOAD;
          dut_in_s = VEC_ZERO;
          busy_s   = 1'b1;
          state_s  = ST_SETTLE;
        end else begin
          busy_s   = 1'b0;
          dut_in_s = VEC_ZERO;
        end
      end

      ST_SETTLE: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_SAMPLE;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end

      ST_SAMPLE: begin
        if (mismatch_s) begin
          err_s = err_r + ERR_ONE;
          if (!ffv_r) begin
            ffv_s   = 1'b1;
            ffvec_s = vec_r;
          end else begin
            ffvec_s = ffvec_r;
          end
        end else begin
          err_s = err_r;
        end

        if (vec_r != VEC_LAST) begin
          vec_s    = vec_r + VEC_ONE;
          dut_in_s = vec_r + VEC_ONE;
          cnt_s    = CNT_LOAD;
          state_s  = ST_SETTLE;
        end else begin
          // pass must see the count including this final vector's result
          state_s  = ST_IDLE;
          done_s   = 1'b1;
          pass_s   = (err_s == ERR_ZERO);
          busy_s   = 1'b0;
          dut_in_s = VEC_ZERO;
          vec_s    = VEC_ZERO;
        end
      end

      default: begin
        state_s  = ST_IDLE;
        vec_s    = VEC_ZERO;
        cnt_s    = CNT_ZERO;
        dut_in_s = VEC_ZERO;
        busy_s   = 1'b0;
        done_s   = 1'b0;
        pass_s   = 1'b0;
        err_s    = ERR_ZERO;
        ffv_s    = 1'b0;
        ffvec_s  = VEC_ZERO;
      end
    endcase
  end

  // State and output registers; reset aborts any sweep without keeping results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      vec_r    <= VEC_ZERO;
      cnt_r    <= CNT_ZERO;
      dut_in_r <= VEC_ZERO;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      pass_r   <= 1'b0;
      err_r    <= ERR_ZERO;
      ffv_r    <= 1'b0;
      ffvec_r  <= VEC_ZERO;
    end else begin
      state_r  <= state_s;
      vec_r    <= vec_s;
      cnt_r    <= cnt_s;
      dut_in_r <= dut_in_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      pass_r   <= pass_s;
      err_r    <= err_s;
      ffv_r    <= ffv_s;
      ffvec_r  <= ffvec_s;
    end
  end

  assign dut_in           = dut_in_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign pass             = pass_r;
  assign err_count        = err_r;
  assign first_fail_valid = ffv_r;
  assign first_fail_vec   = ffvec_r;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Scoreboard bench: two checkers (settle 4 and settle 2) driven against behavioural
// gate models whose truth table and output latency are chosen per sweep.
module tb_gate_truth_table_checker;

  localparam int S_A = 4;
  localparam int S_B = 2;

  typedef struct {
    logic [2:0] err;
    logic       ffv;
    logic [1:0] ffvec;
    logic       pass;
    int         done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic [1:0] dut_in_a, dut_in_b, ffvec_a, ffvec_b, sel_a, sel_b;
  logic dut_out_a, dut_out_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b, ffv_a, ffv_b;
  logic [2:0] err_a, err_b;
  logic done_q_a = 1'b0, done_q_b = 1'b0;
  logic [3:0] gate_tt_a = 4'b0111, gate_tt_b = 4'b0111;
  logic [3:0] nand_tt = 4'b0111;
  int lat_a = 0, lat_b = 0;
  logic [7:0] ph_a = 8'h00, ph_b = 8'h00;
  logic [9:0] full_a, full_b;
  int cyc = 0, ta_start = 0, tb_start = 0;
  int n_vec = 0, n_err = 0;
  exp_t qa[$], qb[$];
  exp_t ea, eb;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gate_truth_table_checker #(.N_IN(2), .SETTLE_CYCLES(S_A), .EXP_TABLE(4'b0111)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .dut_in(dut_in_a), .dut_out(dut_out_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_fail_valid(ffv_a), .first_fail_vec(ffvec_a));

  gate_truth_table_checker #(.N_IN(2), .SETTLE_CYCLES(S_B), .EXP_TABLE(4'b0111)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .dut_in(dut_in_b), .dut_out(dut_out_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_fail_valid(ffv_b), .first_fail_vec(ffvec_b));

  // Gate models: arbitrary truth table seen through an L-cycle register delay.
  always @(posedge clk) begin
    ph_a <= {ph_a[5:0], dut_in_a};
    ph_b <= {ph_b[5:0], dut_in_b};
  end
  always_comb begin
    full_a    = {ph_a, dut_in_a};
    full_b    = {ph_b, dut_in_b};
    sel_a     = full_a[2*lat_a+1 -: 2];
    sel_b     = full_b[2*lat_b+1 -: 2];
    dut_out_a = gate_tt_a[sel_a];
    dut_out_b = gate_tt_b[sel_b];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: vector k is sampled L+1 cycles after... i.e. the gate sees whatever
  // vector was on dut_in at cycle k*(S+1)+S-L relative to the accepting edge (0 before).
  function automatic exp_t model(input logic [3:0] tt, input int s, input int lat, input int t0);
    exp_t e;
    int c, v;
    e.err = 3'd0; e.ffv = 1'b0; e.ffvec = 2'd0;
    for (int k = 0; k < 4; k++) begin
      c = k * (s + 1) + s - lat;
      v = (c < 0) ? 0 : c / (s + 1);
      if (tt[v] != nand_tt[k]) begin
        e.err = e.err + 3'd1;
        if (!e.ffv) begin e.ffv = 1'b1; e.ffvec = 2'(k); end
      end
    end
    e.pass = (e.err == 3'd0);
    e.done_cyc = t0 + 4 * (s + 1);
    return e;
  endfunction

  task automatic chk_done(input string tag, input exp_t e, input logic [2:0] err, input logic ffv,
                          input logic [1:0] ffvec, input logic pass, input logic busy);
    chk({tag, "_err_count"}, int'(err), int'(e.err));
    chk({tag, "_first_fail_valid"}, int'(ffv), int'(e.ffv));
    chk({tag, "_first_fail_vec"}, int'(ffvec), int'(e.ffvec));
    chk({tag, "_pass"}, int'(pass), int'(e.pass));
    chk({tag, "_done_cycle"}, cyc, e.done_cyc);
    chk({tag, "_busy_at_done"}, int'(busy), 0);
  endtask

  // Monitor: checks the applied vector each busy cycle and pops on every done rise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy_a) chk("dut_in_a", int'(dut_in_a), (cyc - ta_start) / (S_A + 1));
      if (busy_b) chk("dut_in_b", int'(dut_in_b), (cyc - tb_start) / (S_B + 1));
      if (done_a && !done_q_a) begin
        if (qa.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_done_a: got done=1 expected no sweep result");
        end else begin
          ea = qa.pop_front();
          chk_done("a", ea, err_a, ffv_a, ffvec_a, pass_a, busy_a);
        end
      end
      if (done_b && !done_q_b) begin
        if (qb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_done_b: got done=1 expected no sweep result");
        end else begin
          eb = qb.pop_front();
          chk_done("b", eb, err_b, ffv_b, ffvec_b, pass_b, busy_b);
        end
      end
    end
    done_q_a <= done_a;
    done_q_b <= done_b;
  end

  task automatic run(input int which, input logic [3:0] tt, input int lat, input bit pulse);
    int n, c;
    logic d;
    if (which == 0) begin gate_tt_a = tt; lat_a = lat; end
    else begin gate_tt_b = tt; lat_b = lat; end
    repeat (6) @(negedge clk);
    if (which == 0) begin
      ta_start = cyc + 1;
      qa.push_back(model(tt, S_A, lat, ta_start));
      start_a = 1'b1;
    end else begin
      tb_start = cyc + 1;
      qb.push_back(model(tt, S_B, lat, tb_start));
      start_b = 1'b1;
    end
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    if (which == 0) begin
      chk("start_clears_done_a", int'(done_a), 0);
      chk("start_clears_err_a", int'(err_a), 0);
      chk("start_sets_busy_a", int'(busy_a), 1);
    end else begin
      chk("start_clears_done_b", int'(done_b), 0);
      chk("start_clears_err_b", int'(err_b), 0);
      chk("start_sets_busy_b", int'(busy_b), 1);
    end
    n = 0;
    d = 1'b0;
    while (!d && n < 200) begin
      @(negedge clk);
      n++;
      c = cyc - ta_start;
      start_a = (which == 0 && pulse && (c == 2 || c == 9));
      d = (which == 0) ? done_a : done_b;
    end
    start_a = 1'b0;
    chk("sweep_timeout", int'(d), 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_dut_in", int'(dut_in_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_pass", int'(pass_a), 0);
    chk("rst_err_count", int'(err_a), 0);
    chk("rst_ffv", int'(ffv_a), 0);
    chk("rst_ffvec", int'(ffvec_a), 0);
    rst_n = 1'b1;

    // Directed cases on the settle-4 checker.
    run(0, 4'b0111, 0, 1'b0);   // ideal NAND
    run(0, 4'b1111, 0, 1'b0);   // stuck at 1
    run(0, 4'b0000, 0, 1'b0);   // stuck at 0
    run(0, 4'b1000, 0, 1'b0);   // AND
    run(0, 4'b0111, 0, 1'b0);   // back to NAND, counts cleared
    run(0, 4'b0111, 0, 1'b1);   // starts pulsed mid-sweep
    repeat (30) @(negedge clk);
    chk("ignored_start_no_resweep_done", int'(done_a), 1);
    chk("ignored_start_no_resweep_busy", int'(busy_a), 0);
    chk("ignored_start_queue_empty", qa.size(), 0);

    // Reset mid-sweep with a stuck-at-0 gate so results are nonzero beforehand.
    gate_tt_a = 4'b0000; lat_a = 0;
    repeat (6) @(negedge clk);
    ta_start = cyc + 1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    while (cyc - ta_start < 6) @(negedge clk);
    chk("err_visible_while_busy", int'(err_a), 1);
    chk("ffv_visible_while_busy", int'(ffv_a), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_dut_in", int'(dut_in_a), 0);
    chk("abort_busy", int'(busy_a), 0);
    chk("abort_done", int'(done_a), 0);
    chk("abort_pass", int'(pass_a), 0);
    chk("abort_err_count", int'(err_a), 0);
    chk("abort_ffv", int'(ffv_a), 0);
    chk("abort_ffvec", int'(ffvec_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 4'b0111, 0, 1'b0);

    // Delayed NAND: fits in settle 4, not in settle 2.
    run(0, 4'b0111, 3, 1'b0);
    run(1, 4'b0111, 3, 1'b0);
    run(1, 4'b0111, 0, 1'b0);

    // Randomized gates and latencies on both checkers.
    for (int i = 0; i < 6; i++) run(0, 4'($urandom), int'($urandom_range(0, 3)), 1'b0);
    for (int i = 0; i < 8; i++) run(1, 4'($urandom), int'($urandom_range(0, 4)), 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_a_drained", qa.size(), 0);
    chk("scoreboard_b_drained", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
